// File: rtl/beam_sweep_scheduler.sv
// ---------------------------------------------------------------------------
// beam_sweep_scheduler
//
// Steps the transmit beamformer across a symmetric fan of angles
// (-MAX_ANGLE .. +MAX_ANGLE in ANGLE_STEP increments). For each beam it loads
// the steering outputs from an internal sine ROM, waits SETTLE_CYCLES with
// transmit off, opens a DWELL_CYCLES transmit window, then waits in HANDOFF
// for the receive side before moving on to the next angle.
//
// Ports
//   clk            system clock
//   rst_in         synchronous active-high reset
//   start_in       level: begin a sweep when idle
//   stop_in        level: abort from any busy state (highest priority)
//   continuous_in  sampled when leaving the last beam: wrap and repeat
//   rx_ready_in    receive side ready, releases HANDOFF
//   sin_theta      |sin(angle)| scaled to 2^(SIN_WIDTH-1)-1
//   sign_bit       1 when the current angle is negative
//   angle_deg      current angle, signed two's complement degrees
//   tx_enable      transmit window
//   beam_done      one-cycle pulse at the end of each dwell
//   busy           high in every state except IDLE
// ---------------------------------------------------------------------------
module beam_sweep_scheduler #(
    parameter int SIN_WIDTH     = 16,
    parameter int MAX_ANGLE     = 60,
    parameter int ANGLE_STEP    = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int DWELL_CYCLES  = 16777216,
    parameter int COUNT_WIDTH   = 25
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 stop_in,
    input  logic                 continuous_in,
    input  logic                 rx_ready_in,
    output logic [SIN_WIDTH-1:0] sin_theta,
    output logic                 sign_bit,
    output logic signed [7:0]    angle_deg,
    output logic                 tx_enable,
    output logic                 beam_done,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_HANDOFF
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] SETTLE_LOAD = COUNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] DWELL_LOAD  = COUNT_WIDTH'(DWELL_CYCLES - 1);
    localparam logic signed [7:0]      MAX_A       = 8'(MAX_ANGLE);
    localparam logic signed [7:0]      MIN_A       = 8'(-MAX_ANGLE);
    localparam logic signed [7:0]      STEP_A      = 8'(ANGLE_STEP);

    // Elaboration-time sine table entry. Taylor series in radians; the tiny
    // bias keeps exact half-way products (e.g. sin 30 deg) rounding upward
    // despite floating-point error just below .5.
    function automatic logic [SIN_WIDTH-1:0] rom_entry(input int deg);
        real x;
        real term;
        real acc;
        real full;
        int  v;
        if (deg > 90) begin
            return '0;
        end
        full = $itor((1 << (SIN_WIDTH - 1)) - 1);
        x    = $itor(deg) * 3.14159265358979323846 / 180.0;
        term = x;
        acc  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        v = $rtoi(acc * full + 0.5 + 1.0e-7);
        return SIN_WIDTH'(v);
    endfunction

    // Sine ROM indexed by |angle|; entries above 90 degrees are never addressed.
    logic [SIN_WIDTH-1:0] sin_rom [0:127];

    genvar gi;
    generate
        for (gi = 0; gi < 128; gi++) begin : g_rom
            localparam logic [SIN_WIDTH-1:0] ENTRY = rom_entry(gi);
            assign sin_rom[gi] = ENTRY;
        end
    endgenerate

    state_t                 state_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [SIN_WIDTH-1:0]   sin_q;
    logic                   sign_q;
    logic signed [7:0]      angle_q;
    logic                   tx_q;
    logic                   done_q;
    logic                   busy_q;

    // Angle loaded on the next SETTLE entry: first beam or wrap restarts at
    // -MAX_ANGLE, otherwise step forward.
    logic signed [7:0] angle_d;
    logic [6:0]        abs_d;

    always_comb begin
        angle_d = MIN_A;
        if (state_q != ST_IDLE && angle_q < MAX_A) begin
            angle_d = angle_q + STEP_A;
        end
        abs_d = angle_d[7] ? 7'(-angle_d) : angle_d[6:0];
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sin_q   <= '0;
            sign_q  <= 1'b0;
            angle_q <= '0;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop_in && state_q != ST_IDLE) begin
                // Abort: steering outputs hold, no beam_done.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                tx_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_in && !stop_in) begin
                            state_q <= ST_SETTLE;
                            cnt_q   <= SETTLE_LOAD;
                            angle_q <= angle_d;
                            sign_q  <= angle_d[7];
                            sin_q   <= sin_rom[abs_d];
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_DWELL;
                            cnt_q   <= DWELL_LOAD;
                            tx_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - COUNT_WIDTH'(1);
                        end
                    end
                    ST_DWELL: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_HANDOFF;
                            cnt_q   <= '0;
                            tx_q    <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - COUNT_WIDTH'(1);
                        end
                    end
                    ST_HANDOFF: begin
                        if (rx_ready_in) begin
                            if (angle_q < MAX_A || continuous_in) begin
                                state_q <= ST_SETTLE;
                                cnt_q   <= SETTLE_LOAD;
                                angle_q <= angle_d;
                                sign_q  <= angle_d[7];
                                sin_q   <= sin_rom[abs_d];
                            end else begin
                                state_q <= ST_IDLE;
                                cnt_q   <= '0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sin_theta = sin_q;
    assign sign_bit  = sign_q;
    assign angle_deg = angle_q;
    assign tx_enable = tx_q;
    assign beam_done = done_q;
    assign busy      = busy_q;

endmodule
